aux_irq_ctrl: RTL and testbench

Interrupt and sampling controller for the registered 32-bit auxiliary GPIO input vector `aux_i`.
- Schedules when `aux_i` is sampled, using a programmable divider that also acts as a coarse debounce.
- Detects per-bit rising and falling edges and latches them into sticky pending bits.
- Masks the pending bits and drives a single level interrupt.
- Configured and serviced through a simple request/acknowledge register port from the system bus bridge.

---
 rtl/aux_gpio_pkg.sv | 16 +
 rtl/aux_edge_sampler.sv | 66 ++++++
 rtl/aux_irq_ctrl.sv | 105 ++++++++++
 tb/tb_aux_irq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/aux_gpio_pkg.sv
// Shared constants for the auxiliary GPIO interrupt controller.
package aux_gpio_pkg;

    localparam int unsigned AUX_WIDTH = 32;
    localparam int unsigned DEF_DIV_W = 16;

    // Word register indices on the register port
    localparam logic [2:0] ADDR_IRQ_EN  = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN = 3'd2;
    localparam logic [2:0] ADDR_PENDING = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;
    localparam logic [2:0] ADDR_DIV     = 3'd5;
    localparam logic [2:0] ADDR_RAW     = 3'd6;

endpackage

// File: rtl/aux_edge_sampler.sv
// Divider-paced sampler of the aux vector with per-bit rise/fall detection.
module aux_edge_sampler
    import aux_gpio_pkg::*;
#(
    parameter int unsigned WIDTH = AUX_WIDTH,
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] aux,
    input  logic [DIV_W-1:0] div,
    input  logic             div_clr,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    output logic             tick_d,
    output logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_q, prev_q;
    logic             primed_q, tick_d_q;
    logic             tick;

    // Tick when the counter reaches DIV; the compare means the counter never wraps
    always_comb begin
        tick  = (cnt_q == div);
        cnt_d = cnt_q + 1'b1;
        if (tick || div_clr) begin
            cnt_d = '0;
        end
    end

    // Counter and sample history; tick_d lags a tick so edges use settled cur/prev
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            cur_q    <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
            tick_d_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (tick) begin
                prev_q   <= cur_q;
                cur_q    <= aux;
                primed_q <= 1'b1;
                // First sample after reset compares against a fake all-zero history
                tick_d_q <= primed_q;
            end else begin
                tick_d_q <= 1'b0;
            end
        end
    end

    // Edge vectors from the two most recent samples
    always_comb begin
        rise = cur_q & ~prev_q & rise_en;
        fall = ~cur_q & prev_q & fall_en;
    end

    assign tick_d = tick_d_q;
    assign cur    = cur_q;

endmodule

// File: rtl/aux_irq_ctrl.sv
// Aux GPIO interrupt controller: register file, sticky pending bits and level irq.
module aux_irq_ctrl
    import aux_gpio_pkg::*;
#(
    parameter int unsigned WIDTH = AUX_WIDTH,
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] aux_i,
    input  logic             reg_req,
    input  logic             reg_we,
    input  logic [2:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic             reg_ack,
    output logic [31:0]      reg_rdata,
    output logic             irq
);

    logic [WIDTH-1:0] irq_en_q, rise_en_q, fall_en_q, pending_q, pending_d;
    logic [DIV_W-1:0] div_q;
    logic             ack_q, irq_q;
    logic [31:0]      rdata_q, rsel;
    logic             accept, wr, div_clr;
    logic [WIDTH-1:0] w1c;
    logic             tick_d;
    logic [WIDTH-1:0] cur, rise, fall;

    aux_edge_sampler #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) u_sampler (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .aux     (aux_i),
        .div     (div_q),
        .div_clr (div_clr),
        .rise_en (rise_en_q),
        .fall_en (fall_en_q),
        .tick_d  (tick_d),
        .cur     (cur),
        .rise    (rise),
        .fall    (fall)
    );

    // Requests arriving during the ack cycle are ignored
    always_comb begin
        accept  = reg_req & ~ack_q;
        wr      = accept & reg_we;
        div_clr = wr && (reg_addr == ADDR_DIV);
        w1c     = (wr && (reg_addr == ADDR_PENDING)) ? reg_wdata[WIDTH-1:0] : '0;
        // OR-ing detect after the clear lets a same-edge set win
        pending_d = (pending_q & ~w1c) | (tick_d ? (rise | fall) : '0);
    end

    // Read mux over pre-update register state
    always_comb begin
        rsel = '0;
        case (reg_addr)
            ADDR_IRQ_EN:  rsel = 32'(irq_en_q);
            ADDR_RISE_EN: rsel = 32'(rise_en_q);
            ADDR_FALL_EN: rsel = 32'(fall_en_q);
            ADDR_PENDING: rsel = 32'(pending_q);
            ADDR_STATUS:  rsel = 32'(pending_q & irq_en_q);
            ADDR_DIV:     rsel = 32'(div_q);
            ADDR_RAW:     rsel = 32'(cur);
            default:      rsel = '0;
        endcase
    end

    // Register file, handshake, pending bits and registered irq
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            div_q     <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= accept;
            pending_q <= pending_d;
            irq_q     <= |(pending_q & irq_en_q);
            if (accept) begin
                rdata_q <= reg_we ? 32'h0 : rsel;
            end
            if (wr) begin
                case (reg_addr)
                    ADDR_IRQ_EN:  irq_en_q  <= reg_wdata[WIDTH-1:0];
                    ADDR_RISE_EN: rise_en_q <= reg_wdata[WIDTH-1:0];
                    ADDR_FALL_EN: fall_en_q <= reg_wdata[WIDTH-1:0];
                    ADDR_DIV:     div_q     <= reg_wdata[DIV_W-1:0];
                    default:      ;
                endcase
            end
        end
    end

    assign reg_ack   = ack_q;
    assign reg_rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_aux_irq_ctrl.sv
// Directed, table-driven bench for aux_irq_ctrl.
module tb_aux_irq_ctrl;

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] aux_i;
    logic        reg_req;
    logic        reg_we;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    aux_irq_ctrl dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .aux_i     (aux_i),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata),
        .irq       (irq)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One register access; returns read data and checks the ack is a single cycle
    task automatic access(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        bit got;
        got = 0;
        rd  = 'x;
        @(negedge sys_clk);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wd;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            if (reg_ack) begin
                got = 1;
                rd  = reg_rdata;
                break;
            end
        end
        reg_req = 1'b0;
        reg_we  = 1'b0;
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(negedge sys_clk);
        chk("ack_one_cycle", 32'(reg_ack), 32'd0);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        access(1'b1, addr, wd, rd);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        access(1'b0, addr, 32'h0, rd);
        chk(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;

        sys_rst = 1'b1; aux_i = '0; reg_req = 0; reg_we = 0; reg_addr = '0; reg_wdata = '0;

        // Register access table: reset values, RW behaviour, RO/unused addresses
        for (int a = 0; a < 8; a++) tbl[a] = '{1'b0, 3'(a), 32'h0, 32'h0};
        tbl[8]  = '{1'b1, 3'd0, 32'h12345678, 32'h0};
        tbl[9]  = '{1'b0, 3'd0, 32'h0,        32'h12345678};
        tbl[10] = '{1'b1, 3'd2, 32'hCAFEF00D, 32'h0};
        tbl[11] = '{1'b0, 3'd2, 32'h0,        32'hCAFEF00D};
        tbl[12] = '{1'b1, 3'd5, 32'hFFFFFFFF, 32'h0};
        tbl[13] = '{1'b0, 3'd5, 32'h0,        32'h0000FFFF};
        tbl[14] = '{1'b1, 3'd7, 32'hFFFFFFFF, 32'h0};
        tbl[15] = '{1'b0, 3'd7, 32'h0,        32'h0};
        tbl[16] = '{1'b1, 3'd6, 32'h00001234, 32'h0};
        tbl[17] = '{1'b0, 3'd6, 32'h0,        32'h0};
        tbl[18] = '{1'b0, 3'd4, 32'h0,        32'h0};
        tbl[19] = '{1'b1, 3'd0, 32'h0,        32'h0};
        tbl[20] = '{1'b1, 3'd2, 32'h0,        32'h0};
        tbl[21] = '{1'b1, 3'd5, 32'h0,        32'h0};
        tbl[22] = '{1'b0, 3'd0, 32'h0,        32'h0};
        tbl[23] = '{1'b0, 3'd5, 32'h0,        32'h0};

        repeat (3) @(negedge sys_clk);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_ack", 32'(reg_ack), 32'd0);
        sys_rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            access(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
            chk($sformatf("tbl%0d_a%0d", i, tbl[i].addr), rd, tbl[i].exp);
            chk("tbl_irq_low", 32'(irq), 32'd0);
        end

        // Rising edge on bit 0 with DIV = 0: pending at E+1, irq at E+2
        wr(3'd1, 32'h1);
        wr(3'd0, 32'h1);
        repeat (3) @(negedge sys_clk);
        aux_i = 32'h1;
        @(negedge sys_clk);  // after capture edge E
        chk("irq_e0", 32'(irq), 32'd0);
        @(negedge sys_clk);  // after E+1
        chk("irq_e1", 32'(irq), 32'd0);
        @(negedge sys_clk);  // after E+2
        chk("irq_e2", 32'(irq), 32'd1);
        rd_chk("pend_rise", 3'd3, 32'h1);
        rd_chk("status_rise", 3'd4, 32'h1);
        wr(3'd3, 32'h1);
        chk("irq_after_w1c", 32'(irq), 32'd0);
        rd_chk("pend_cleared", 3'd3, 32'h0);

        // Falling edges on all bits; STATUS masked by IRQ_EN = 0
        wr(3'd0, 32'h0);
        aux_i = 32'h0;
        repeat (3) @(negedge sys_clk);
        wr(3'd2, 32'hFFFFFFFF);
        aux_i = 32'hDEADBEEF;
        repeat (4) @(negedge sys_clk);
        aux_i = 32'h0;
        repeat (4) @(negedge sys_clk);
        rd_chk("pend_deadbeef", 3'd3, 32'hDEADBEEF);
        rd_chk("status_masked", 3'd4, 32'h0);
        chk("irq_masked", 32'(irq), 32'd0);
        wr(3'd3, 32'hFFFFFFFF);
        rd_chk("pend_clr_all", 3'd3, 32'h0);

        // Priming: RISE_EN write accepted on the very first edge after reset
        @(negedge sys_clk);
        sys_rst = 1'b1; aux_i = 32'hA5A5A5A5;
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = 3'd1; reg_wdata = 32'hFFFFFFFF;
        repeat (3) begin
            @(negedge sys_clk);
            chk("ack_in_reset", 32'(reg_ack), 32'd0);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("prime_wr_ack", 32'(reg_ack), 32'd1);
        reg_req = 1'b0; reg_we = 1'b0;
        wr(3'd2, 32'hFFFFFFFF);
        repeat (4) @(negedge sys_clk);
        rd_chk("prime_no_pend", 3'd3, 32'h0);
        rd_chk("prime_raw", 3'd6, 32'hA5A5A5A5);

        // Set beats a same-edge write-1-to-clear on bit 3
        wr(3'd2, 32'h0);
        wr(3'd1, 32'h8);
        aux_i = 32'h0;
        repeat (3) @(negedge sys_clk);
        wr(3'd3, 32'hFFFFFFFF);
        rd_chk("pend_pre_race", 3'd3, 32'h0);
        aux_i = 32'h8;                    // captured at edge E
        @(negedge sys_clk);
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = 3'd3; reg_wdata = 32'h8;  // accepted at E+1
        @(negedge sys_clk);
        chk("race_ack", 32'(reg_ack), 32'd1);
        reg_req = 1'b0; reg_we = 1'b0;
        rd_chk("pend_set_wins", 3'd3, 32'h8);
        wr(3'd3, 32'h8);
        rd_chk("pend_race_clr", 3'd3, 32'h0);

        // DIV = 4: ticks every 5 cycles, first at W+5 after the DIV write edge W
        wr(3'd1, 32'h1);
        aux_i = 32'h0;
        repeat (3) @(negedge sys_clk);
        wr(3'd3, 32'hFFFFFFFF);
        wr(3'd5, 32'h4);                  // returns at W+1.5
        aux_i = 32'h1;                    // seen only at edges W+2, W+3
        @(negedge sys_clk);
        reg_req = 1'b1; reg_we = 1'b0; reg_addr = 3'd6;  // read RAW accepted at W+3
        @(negedge sys_clk);
        chk("raw_between_ack", 32'(reg_ack), 32'd1);
        chk("raw_between_ticks", reg_rdata, 32'h0);
        reg_req = 1'b0;
        aux_i = 32'h0;
        repeat (12) @(negedge sys_clk);
        rd_chk("short_pulse_pend", 3'd3, 32'h0);
        aux_i = 32'h100;
        repeat (6) @(negedge sys_clk);
        rd_chk("raw_at_tick", 3'd6, 32'h100);
        aux_i = 32'h101;
        repeat (6) @(negedge sys_clk);
        aux_i = 32'h0;
        repeat (12) @(negedge sys_clk);
        rd_chk("long_pulse_pend", 3'd3, 32'h1);
        rd_chk("raw_final", 3'd6, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
